// File: rtl/debug_mem_writer_pkg.sv
// debug_mem_writer_pkg: shared target codes, error bit indices and FSM states (DEBUG_MEM_WRITER_READBACK_EN adds CHK states)
package debug_mem_writer_pkg;
  localparam logic [1:0] TGT_MEM = 2'd0;
  localparam logic [1:0] TGT_REG = 2'd1;
  localparam logic [1:0] TGT_PSW = 2'd2;
  localparam int ERR_TIMEOUT  = 0;
  localparam int ERR_READBACK = 1;
`ifdef DEBUG_MEM_WRITER_READBACK_EN
  typedef enum logic [3:0] {
    IDLE, LO_REQ, LO_WAIT, LO_CHK, HI_REQ, HI_WAIT, HI_CHK, INC, REG_WR, PSW_WR
  } state_t;
`else
  typedef enum logic [3:0] {
    IDLE, LO_REQ, LO_WAIT, HI_REQ, HI_WAIT, INC, REG_WR, PSW_WR
  } state_t;
`endif
  function automatic logic [1:0] next_target(input logic [1:0] t);
    return (t == TGT_PSW) ? TGT_MEM : t + 2'd1;
  endfunction
endpackage

// File: rtl/debug_mem_writer_key_debounce.sv
// key_debounce: 2-FF synchroniser, stability counter and one-cycle press pulse for an active-low key
module key_debounce #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic press
);
  localparam int CW = DEB_CYCLES > 1 ? $clog2(DEB_CYCLES) : 1;
  logic [1:0]    sync;
  logic          lvl;
  logic [CW-1:0] cnt;
  logic          done;
  assign done = cnt == CW'(DEB_CYCLES - 1);
  // accept a new level only after it has differed from the current one for DEB_CYCLES cycles; pulse on 1->0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= 2'b11;
      lvl   <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], key};
      press <= (sync[1] != lvl) && done && lvl;
      if (sync[1] == lvl) cnt <= '0;
      else if (done) begin
        lvl <= sync[1];
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/debug_mem_writer.sv
// debug_mem_writer: front-panel word writer to byte memory, register file or PSW (DEBUG_MEM_WRITER_READBACK_EN enables byte readback check)
module debug_mem_writer
  import debug_mem_writer_pkg::*;
#(
  parameter int DEB_CYCLES  = 50000,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] sw,
  input  logic [3:0]  key,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        reg_we,
  output logic [2:0]  reg_num,
  output logic [15:0] reg_wdata,
  output logic        psw_we,
  output logic [15:0] psw_wdata,
  output logic [15:0] cur_addr,
  output logic [1:0]  target,
  output logic        busy,
  output logic [1:0]  err
);
  localparam int TW = ACK_TIMEOUT > 1 ? $clog2(ACK_TIMEOUT + 1) : 1;
  state_t        state, state_n;
  logic [3:1]    press;
  logic [15:0]   word;
  logic [TW-1:0] wcnt;
  logic          waiting, tmo, hi, go;
`ifdef DEBUG_MEM_WRITER_READBACK_EN
  wire unused_ok = key[0];
`else
  wire unused_ok = ^{key[0], mem_rdata};
`endif
  for (genvar i = 1; i < 4; i++) begin : g_key
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk  (clk),
      .rst_n(rst_n),
      .key  (key[i]),
      .press(press[i])
    );
  end
  assign waiting   = state inside {LO_WAIT, HI_WAIT};
  assign tmo       = wcnt == TW'(ACK_TIMEOUT - 1);
`ifdef DEBUG_MEM_WRITER_READBACK_EN
  assign hi        = state inside {HI_REQ, HI_WAIT, HI_CHK};
`else
  assign hi        = state inside {HI_REQ, HI_WAIT};
`endif
  assign go        = press[2] && !press[1] && !press[3];
  assign mem_req   = state inside {LO_REQ, LO_WAIT, HI_REQ, HI_WAIT};
  assign mem_addr  = hi ? cur_addr + 16'd1 : cur_addr;
  assign mem_wdata = hi ? word[15:8] : word[7:0];
  assign reg_we    = state == REG_WR;
  assign reg_num   = cur_addr[2:0];
  assign reg_wdata = word;
  assign psw_we    = state == PSW_WR;
  assign psw_wdata = word;
  assign busy      = state != IDLE;
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  // next-state: dispatch on target, step through the two byte writes, bail out on timeout
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = !go ? IDLE : target == TGT_MEM ? LO_REQ : target == TGT_REG ? REG_WR :
                         target == TGT_PSW ? PSW_WR : IDLE;
      LO_REQ:  state_n = LO_WAIT;
`ifdef DEBUG_MEM_WRITER_READBACK_EN
      LO_WAIT: state_n = mem_ack ? LO_CHK : tmo ? IDLE : LO_WAIT;
      LO_CHK:  state_n = HI_REQ;
      HI_WAIT: state_n = mem_ack ? HI_CHK : tmo ? IDLE : HI_WAIT;
      HI_CHK:  state_n = INC;
`else
      LO_WAIT: state_n = mem_ack ? HI_REQ : tmo ? IDLE : LO_WAIT;
      HI_WAIT: state_n = mem_ack ? INC : tmo ? IDLE : HI_WAIT;
`endif
      HI_REQ:  state_n = HI_WAIT;
      default: state_n = IDLE;
    endcase
  end
  // datapath: address pointer, target selector, latched word, ack wait counter and error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr <= '0;
      target   <= TGT_MEM;
      word     <= '0;
      wcnt     <= '0;
      err      <= '0;
    end else begin
      wcnt <= waiting ? wcnt + 1'b1 : '0;
      if (state == IDLE) begin
        if (press[1]) cur_addr <= sw;
        else if (press[3]) target <= next_target(target);
        else if (press[2]) begin
          word <= sw;
          err  <= '0;
        end
      end
      if (state == REG_WR) cur_addr[2:0] <= cur_addr[2:0] + 3'd1;
      if (state == INC) cur_addr <= cur_addr + 16'd2;
      if (waiting && !mem_ack && tmo) err[ERR_TIMEOUT] <= 1'b1;
`ifdef DEBUG_MEM_WRITER_READBACK_EN
      if ((state == LO_CHK && mem_rdata != word[7:0]) || (state == HI_CHK && mem_rdata != word[15:8]))
        err[ERR_READBACK] <= 1'b1;
`endif
    end
  end
endmodule

// File: tb/tb_debug_mem_writer.sv
// tb_debug_mem_writer: directed tests for debug_mem_writer with a small acknowledging memory model
module tb_debug_mem_writer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] sw;
  logic [3:0]  key;
  logic        mem_req, mem_ack, reg_we, psw_we, busy;
  logic [15:0] mem_addr, reg_wdata, psw_wdata, cur_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic [2:0]  reg_num;
  logic [1:0]  target, err;
  int checks = 0, errors = 0;
  int ack_dly = 2, acnt = 0, n_wr = 0, req_cycles = 0, reg_cnt = 0, psw_cnt = 0;
  bit ack_en = 1'b1, rb_bad = 1'b0;
  logic [15:0] wa [16];
  logic [7:0]  wd [16];
  logic [2:0]  rn;
  logic [15:0] rw, pw;

  debug_mem_writer #(.DEB_CYCLES(4), .ACK_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .key(key),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .reg_we(reg_we), .reg_num(reg_num), .reg_wdata(reg_wdata),
    .psw_we(psw_we), .psw_wdata(psw_wdata),
    .cur_addr(cur_addr), .target(target), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    mem_ack = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (mem_ack) mem_ack = 1'b0;
      else if (mem_req && ack_en) begin
        acnt++;
        if (acnt == ack_dly) begin
          mem_ack = 1'b1;
          acnt = 0;
          mem_rdata = rb_bad ? 8'h00 : mem_wdata;
          if (n_wr < 16) begin
            wa[n_wr] = mem_addr;
            wd[n_wr] = mem_wdata;
          end
          n_wr++;
        end
      end else acnt = 0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (mem_req) req_cycles++;
    if (reg_we) begin
      reg_cnt++;
      rn = reg_num;
      rw = reg_wdata;
    end
    if (psw_we) begin
      psw_cnt++;
      pw = psw_wdata;
    end
  end

  task automatic press(input int k);
    key[k] = 1'b0;
    repeat (8) @(negedge clk);
    key[k] = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle busy=%b required 0 after %0d cycles", busy, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    key = 4'hF;
    sw = 16'h0000;
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_req, reg_we, psw_we, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_strobes got %b required 0000", {mem_req, reg_we, psw_we, busy});
    end
    checks++;
    if ({cur_addr, target, err} !== 20'h0) begin
      errors++;
      $display("FAIL reset_state cur_addr=%h target=%0d err=%b required 0", cur_addr, target, err);
    end
    checks++;
    if ({mem_addr, mem_wdata, reg_wdata, psw_wdata} !== 56'h0) begin
      errors++;
      $display("FAIL reset_data addr=%h wdata=%h reg=%h psw=%h required 0", mem_addr, mem_wdata, reg_wdata, psw_wdata);
    end
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_mem_write();
    sw = 16'h0100;
    press(1);
    checks++;
    if (cur_addr !== 16'h0100) begin
      errors++;
      $display("FAIL load_addr got %h required 0100", cur_addr);
    end
    n_wr = 0;
    sw = 16'hBEEF;
    press(2);
    wait_idle();
    checks++;
    if (n_wr !== 2 || wa[0] !== 16'h0100 || wd[0] !== 8'hEF || wa[1] !== 16'h0101 || wd[1] !== 8'hBE) begin
      errors++;
      $display("FAIL mem_word n=%0d %h:%h %h:%h required 2 0100:ef 0101:be", n_wr, wa[0], wd[0], wa[1], wd[1]);
    end
    checks++;
    if (cur_addr !== 16'h0102 || err !== 2'b00) begin
      errors++;
      $display("FAIL mem_inc cur_addr=%h err=%b required 0102 00", cur_addr, err);
    end
  endtask

  task automatic test_wrap();
    sw = 16'hFFFF;
    press(1);
    n_wr = 0;
    sw = 16'h1234;
    press(2);
    wait_idle();
    checks++;
    if (n_wr !== 2 || wa[0] !== 16'hFFFF || wd[0] !== 8'h34 || wa[1] !== 16'h0000 || wd[1] !== 8'h12) begin
      errors++;
      $display("FAIL wrap_bytes n=%0d %h:%h %h:%h required 2 ffff:34 0000:12", n_wr, wa[0], wd[0], wa[1], wd[1]);
    end
    checks++;
    if (cur_addr !== 16'h0001) begin
      errors++;
      $display("FAIL wrap_addr got %h required 0001", cur_addr);
    end
  endtask

  task automatic test_reg_psw();
    press(3);
    checks++;
    if (target !== 2'd1) begin
      errors++;
      $display("FAIL target_reg got %0d required 1", target);
    end
    sw = 16'h0007;
    press(1);
    n_wr = 0;
    reg_cnt = 0;
    sw = 16'h00AA;
    press(2);
    wait_idle();
    checks++;
    if (reg_cnt !== 1 || rn !== 3'd7 || rw !== 16'h00AA || n_wr !== 0) begin
      errors++;
      $display("FAIL reg_write cnt=%0d num=%0d data=%h memw=%0d required 1 7 00aa 0", reg_cnt, rn, rw, n_wr);
    end
    checks++;
    if (cur_addr !== 16'h0000) begin
      errors++;
      $display("FAIL reg_inc got %h required 0000", cur_addr);
    end
    press(3);
    psw_cnt = 0;
    sw = 16'h8001;
    press(2);
    wait_idle();
    checks++;
    if (target !== 2'd2 || psw_cnt !== 1 || pw !== 16'h8001 || cur_addr !== 16'h0000) begin
      errors++;
      $display("FAIL psw_write tgt=%0d cnt=%0d data=%h addr=%h required 2 1 8001 0000", target, psw_cnt, pw, cur_addr);
    end
    press(3);
    checks++;
    if (target !== 2'd0) begin
      errors++;
      $display("FAIL target_wrap got %0d required 0", target);
    end
  endtask

  task automatic test_timeout();
    sw = 16'h0200;
    press(1);
    ack_en = 1'b0;
    n_wr = 0;
    req_cycles = 0;
    sw = 16'hBEEF;
    press(2);
    wait_idle();
    checks++;
    if (req_cycles !== 9 || err !== 2'b01 || cur_addr !== 16'h0200 || n_wr !== 0) begin
      errors++;
      $display("FAIL timeout req=%0d err=%b addr=%h n=%0d required 9 01 0200 0", req_cycles, err, cur_addr, n_wr);
    end
    ack_en = 1'b1;
    sw = 16'h1111;
    press(2);
    wait_idle();
    checks++;
    if (err !== 2'b00 || n_wr !== 2 || cur_addr !== 16'h0202) begin
      errors++;
      $display("FAIL err_clear err=%b n=%0d addr=%h required 00 2 0202", err, n_wr, cur_addr);
    end
  endtask

  task automatic test_robust();
    sw = 16'h5555;
    key[1] = 1'b0;
    repeat (3) @(negedge clk);
    key[1] = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if (cur_addr !== 16'h0202) begin
      errors++;
      $display("FAIL bounce got %h required 0202", cur_addr);
    end
    n_wr = 0;
    sw = 16'h0300;
    key[1] = 1'b0;
    key[2] = 1'b0;
    repeat (8) @(negedge clk);
    key[1] = 1'b1;
    key[2] = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if (cur_addr !== 16'h0300 || n_wr !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL simultaneous addr=%h n=%0d busy=%b required 0300 0 0", cur_addr, n_wr, busy);
    end
  endtask

  task automatic test_busy_ignore();
    sw = 16'h0500;
    press(1);
    ack_dly = 7;
    n_wr = 0;
    sw = 16'hCAFE;
    key[2] = 1'b0;
    repeat (7) @(negedge clk);
    key[2] = 1'b1;
    repeat (6) @(negedge clk);
    key[2] = 1'b0;
    repeat (8) @(negedge clk);
    key[2] = 1'b1;
    wait_idle();
    repeat (20) @(negedge clk);
    checks++;
    if (n_wr !== 2 || cur_addr !== 16'h0502 || wa[0] !== 16'h0500 || wd[0] !== 8'hFE) begin
      errors++;
      $display("FAIL busy_ignore n=%0d addr=%h first=%h:%h required 2 0502 0500:fe", n_wr, cur_addr, wa[0], wd[0]);
    end
    ack_dly = 2;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    sw = 16'h0400;
    press(1);
    ack_en = 1'b0;
    n_wr = 0;
    sw = 16'h7777;
    key[2] = 1'b0;
    while (!mem_req && n < 30) begin
      @(negedge clk);
      n++;
    end
    key[2] = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_write_start req=%b busy=%b required 1 1", mem_req, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || cur_addr !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid req=%b busy=%b addr=%h required 0 0 0000", mem_req, busy, cur_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ack_en = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || n_wr !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL no_retry req=%b n=%0d busy=%b required 0 0 0", mem_req, n_wr, busy);
    end
  endtask

`ifdef DEBUG_MEM_WRITER_READBACK_EN
  task automatic test_readback();
    sw = 16'h0100;
    press(1);
    rb_bad = 1'b1;
    n_wr = 0;
    sw = 16'hBEEF;
    press(2);
    wait_idle();
    rb_bad = 1'b0;
    checks++;
    if (err !== 2'b10 || n_wr !== 2 || wd[1] !== 8'hBE || cur_addr !== 16'h0102) begin
      errors++;
      $display("FAIL readback err=%b n=%0d hi=%h addr=%h required 10 2 be 0102", err, n_wr, wd[1], cur_addr);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_mem_write();
    test_wrap();
    test_reg_psw();
    test_timeout();
    test_robust();
    test_busy_ignore();
    test_reset_mid();
`ifdef DEBUG_MEM_WRITER_READBACK_EN
    test_readback();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
